ray_scheduler: RTL and testbench

Frame-level scheduler that feeds a pool of `NUM_UNITS` ray units. It walks the output frame in raster order and computes each pixel's ray direction incrementally. It hands each ray, with its pixel address, to a free unit through round-robin arbitration, and reports frame completion once every unit has drained. It sits between the frame/camera control registers and the ray unit array, which shares one memory bus behind it.

---
 rtl/ray_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/ray_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_ray_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared types for the ray scheduler: vector type, scheduler states and
// the default pixel stride.
package ray_pkg;

    localparam int VEC_WIDTH   = 16;
    localparam int PIXEL_BYTES = 4;

    typedef logic [3*VEC_WIDTH-1:0] vec3_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_DISPATCH,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search begins at i_pointer and wraps; the next
// pointer is the unit following the winner.
module rr_arbiter #(
    parameter int N         = 4,
    parameter int PTR_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         i_request,
    input  logic [PTR_WIDTH-1:0] i_pointer,
    output logic [N-1:0]         o_grant,
    output logic [PTR_WIDTH-1:0] o_next_pointer
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_grant        = '0;
        o_next_pointer = i_pointer;
        w_found        = 1'b0;
        w_idx          = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_pointer) + k) % N;
            if (!w_found && i_request[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_next_pointer = PTR_WIDTH'((w_idx + 1) % N);
            end
        end
    end

endmodule

// File: rtl/ray_scheduler.sv
// Frame scheduler: walks the frame in raster order, steps the ray direction
// incrementally and hands each pixel to a free ray unit round-robin.
module ray_scheduler #(
    parameter int NUM_UNITS      = 4,
    parameter int POSITION_WIDTH = 16,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DIM_WIDTH      = 12,
    parameter int PIXEL_BYTES    = ray_pkg::PIXEL_BYTES
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        frameStart,
    input  logic                        frameFlush,
    input  logic [DIM_WIDTH-1:0]        frameWidth,
    input  logic [DIM_WIDTH-1:0]        frameHeight,
    input  logic [ADDRESS_WIDTH-1:0]    frameAddress,
    input  logic [3*POSITION_WIDTH-1:0] cameraQ,
    input  logic [3*POSITION_WIDTH-1:0] baseV,
    input  logic [3*POSITION_WIDTH-1:0] deltaX,
    input  logic [3*POSITION_WIDTH-1:0] deltaY,
    output logic                        frameBusy,
    output logic                        frameDone,
    output logic [NUM_UNITS-1:0]        unitStart,
    input  logic [NUM_UNITS-1:0]        unitBusy,
    output logic                        unitFlush,
    output logic [3*POSITION_WIDTH-1:0] rayQ,
    output logic [3*POSITION_WIDTH-1:0] rayV,
    output logic [ADDRESS_WIDTH-1:0]    pixelAddress
);

    import ray_pkg::*;

    localparam int PTR_WIDTH = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int VW        = 3 * POSITION_WIDTH;
    localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

    sched_state_t               r_state;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_flush;
    logic [NUM_UNITS-1:0]       r_granted_last;
    logic [PTR_WIDTH-1:0]       r_pointer;
    logic [DIM_WIDTH-1:0]       r_width;
    logic [DIM_WIDTH-1:0]       r_height;
    logic [DIM_WIDTH-1:0]       r_x;
    logic [DIM_WIDTH-1:0]       r_y;
    logic [VW-1:0]              r_q;
    logic [VW-1:0]              r_v;
    logic [VW-1:0]              r_row_v;
    logic [VW-1:0]              r_dx;
    logic [VW-1:0]              r_dy;
    logic [ADDRESS_WIDTH-1:0]   r_address;

    logic [NUM_UNITS-1:0]       w_request;
    logic [NUM_UNITS-1:0]       w_arb_grant;
    logic [NUM_UNITS-1:0]       w_grant;
    logic [PTR_WIDTH-1:0]       w_next_pointer;
    logic [VW-1:0]              w_col_next;
    logic [VW-1:0]              w_row_next;
    logic                       w_last_col;
    logic                       w_last_row;

    // Units granted last cycle may not show busy yet, so they are excluded.
    assign w_request = ~unitBusy & ~r_granted_last;

    rr_arbiter #(
        .N         (NUM_UNITS),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_arbiter (
        .i_request      (w_request),
        .i_pointer      (r_pointer),
        .o_grant        (w_arb_grant),
        .o_next_pointer (w_next_pointer)
    );

    assign w_grant    = (r_state == ST_DISPATCH) ? w_arb_grant : '0;
    assign w_last_col = (r_x == r_width - DIM_ONE);
    assign w_last_row = (r_y == r_height - DIM_ONE);

    // Direction components wrap independently; no carry between them.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_component
            assign w_col_next[gi*POSITION_WIDTH +: POSITION_WIDTH] =
                r_v[gi*POSITION_WIDTH +: POSITION_WIDTH] + r_dx[gi*POSITION_WIDTH +: POSITION_WIDTH];
            assign w_row_next[gi*POSITION_WIDTH +: POSITION_WIDTH] =
                r_row_v[gi*POSITION_WIDTH +: POSITION_WIDTH] + r_dy[gi*POSITION_WIDTH +: POSITION_WIDTH];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_flush        <= 1'b0;
            r_granted_last <= '0;
            r_pointer      <= '0;
            r_width        <= '0;
            r_height       <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_q            <= '0;
            r_v            <= '0;
            r_row_v        <= '0;
            r_dx           <= '0;
            r_dy           <= '0;
            r_address      <= '0;
        end else begin
            r_flush        <= 1'b0;
            r_done         <= 1'b0;
            r_granted_last <= w_grant;
            case (r_state)
                ST_IDLE: begin
                    // r_busy stays high through the done pulse, blocking a start there.
                    if (r_done) begin
                        r_busy <= 1'b0;
                    end else if (frameStart && !r_busy) begin
                        r_busy    <= 1'b1;
                        r_width   <= frameWidth;
                        r_height  <= frameHeight;
                        r_q       <= cameraQ;
                        r_v       <= baseV;
                        r_row_v   <= baseV;
                        r_dx      <= deltaX;
                        r_dy      <= deltaY;
                        r_address <= frameAddress;
                        r_x       <= '0;
                        r_y       <= '0;
                        if (frameWidth == '0 || frameHeight == '0) begin
                            r_state <= ST_DONE;
                        end else if (frameFlush) begin
                            r_flush <= 1'b1;
                            r_state <= ST_FLUSH;
                        end else begin
                            r_state <= ST_DISPATCH;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_DISPATCH;
                end
                ST_DISPATCH: begin
                    if (w_grant != '0) begin
                        r_pointer <= w_next_pointer;
                        r_address <= r_address + ADDRESS_WIDTH'(PIXEL_BYTES);
                        if (w_last_col) begin
                            r_x     <= '0;
                            r_y     <= r_y + DIM_ONE;
                            r_row_v <= w_row_next;
                            r_v     <= w_row_next;
                            if (w_last_row) begin
                                r_state <= ST_DRAIN;
                            end
                        end else begin
                            r_x <= r_x + DIM_ONE;
                            r_v <= w_col_next;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (unitBusy == '0 && r_granted_last == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign frameBusy    = r_busy;
    assign frameDone    = r_done;
    assign unitFlush    = r_flush;
    assign unitStart    = w_grant;
    assign rayQ         = r_q;
    assign rayV         = r_v;
    assign pixelAddress = r_address;

endmodule

// File: tb/tb_ray_scheduler.sv
// Self-checking bench for ray_scheduler: directed frames plus randomized
// frames, checked cycle by cycle against a behavioural unit-pool model.
module tb_ray_scheduler;

    import ray_pkg::*;

    localparam int NU = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        frameStart;
    logic        frameFlush;
    logic [11:0] frameWidth;
    logic [11:0] frameHeight;
    logic [31:0] frameAddress;
    vec3_t       cameraQ;
    vec3_t       baseV;
    vec3_t       deltaX;
    vec3_t       deltaY;
    logic        frameBusy;
    logic        frameDone;
    logic [NU-1:0] unitStart;
    logic [NU-1:0] unitBusy;
    logic        unitFlush;
    vec3_t       rayQ;
    vec3_t       rayV;
    logic [31:0] pixelAddress;

    int vectors     = 0;
    int miscompares = 0;

    int            busy_cnt[NU];
    int            m_ptr  = 0;
    logic [NU-1:0] m_last = '0;
    int            glog[$];

    always #5 clock = ~clock;

    ray_scheduler #(
        .NUM_UNITS      (NU),
        .POSITION_WIDTH (16),
        .ADDRESS_WIDTH  (32),
        .DIM_WIDTH      (12),
        .PIXEL_BYTES    (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frameStart   (frameStart),
        .frameFlush   (frameFlush),
        .frameWidth   (frameWidth),
        .frameHeight  (frameHeight),
        .frameAddress (frameAddress),
        .cameraQ      (cameraQ),
        .baseV        (baseV),
        .deltaX       (deltaX),
        .deltaY       (deltaY),
        .frameBusy    (frameBusy),
        .frameDone    (frameDone),
        .unitStart    (unitStart),
        .unitBusy     (unitBusy),
        .unitFlush    (unitFlush),
        .rayQ         (rayQ),
        .rayV         (rayV),
        .pixelAddress (pixelAddress)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Direction of pixel (x,y) in closed form: base + x*dx + y*dy per component.
    function automatic vec3_t exp_dir(vec3_t bv, vec3_t dx, vec3_t dy, int x, int y);
        vec3_t r;
        logic [15:0] b, a, d;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            b = bv[c*16 +: 16];
            a = dx[c*16 +: 16];
            d = dy[c*16 +: 16];
            r[c*16 +: 16] = b + 16'(x) * a + 16'(y) * d;
        end
        return r;
    endfunction

    function automatic int rr_pick(logic [NU-1:0] free, int ptr);
        for (int k = 0; k < NU; k++) begin
            if (free[(ptr + k) % NU]) return (ptr + k) % NU;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(logic [NU-1:0] v);
        for (int i = 0; i < NU; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NU-1:0] busy_now();
        logic [NU-1:0] b;
        b = '0;
        for (int i = 0; i < NU; i++) b[i] = (busy_cnt[i] > 0);
        return b;
    endfunction

    // Advance the unit pool one clock: started units stay busy for a random time.
    task automatic tick_units(input logic [NU-1:0] g, input int dmin, input int dmax, input bit rst);
        for (int i = 0; i < NU; i++) if (busy_cnt[i] > 0) busy_cnt[i]--;
        for (int i = 0; i < NU; i++) begin
            if (g[i]) begin
                busy_cnt[i] = int'($urandom_range(dmax, dmin));
                m_ptr = (i + 1) % NU;
            end
        end
        m_last = g;
        if (rst) begin
            m_ptr  = 0;
            m_last = '0;
        end
    endtask

    task automatic run_frame(input int w, input int h, input bit flush, input logic [31:0] base,
                             input vec3_t q, input vec3_t bv, input vec3_t dx, input vec3_t dy,
                             input int dmin, input int dmax, input logic [NU-1:0] mask,
                             input int hold_at, input int hold_len, input int abort_at);
        int n, k, first, last_g, done_at, holds, flushes, pick;
        logic [NU-1:0] busy_v, exp_g, prev_g;
        n = w * h; k = 0; first = flush ? 2 : 1; last_g = -1;
        done_at = (n == 0) ? 2 : -1; holds = 0; flushes = 0; pick = -1; prev_g = '0;
        glog.delete();
        @(negedge clock);
        reset = 1'b0; frameStart = 1'b1; frameFlush = flush;
        frameWidth = 12'(w); frameHeight = 12'(h); frameAddress = base;
        cameraQ = q; baseV = bv; deltaX = dx; deltaY = dy;
        unitBusy = busy_now() | ((n > 0) ? mask : '0);
        #1;
        chk("busy_before_start", frameBusy, 0);
        @(posedge clock);
        tick_units('0, dmin, dmax, 1'b0);
        for (int t = 1; t < 3000; t++) begin
            @(negedge clock);
            frameStart = 1'b0; frameFlush = 1'b0;
            reset = (t == abort_at);
            busy_v = busy_now();
            if (k < n) busy_v = busy_v | mask;
            if (t >= hold_at && t < hold_at + hold_len) busy_v = '1;
            unitBusy = busy_v;
            #1;
            exp_g = '0;
            if (t >= first && k < n) begin
                pick = rr_pick(~busy_v & ~m_last, m_ptr);
                if (pick >= 0) exp_g[pick] = 1'b1;
            end
            chk("unitStart", unitStart, exp_g);
            chk("lag", unitStart & prev_g, '0);
            chk("unitFlush", unitFlush, flush && n > 0 && t == 1);
            if (t >= hold_at && t < hold_at + hold_len && unitStart != '0) holds++;
            if (unitFlush) flushes++;
            if (unitStart != '0) begin
                glog.push_back(onehot_idx(unitStart));
                $display("grant u%0d pixel %0d addr %h dir %h", onehot_idx(unitStart), k, pixelAddress, rayV);
            end
            if (exp_g != '0) begin
                chk("pixelAddress", pixelAddress, base + 32'(k * PIXEL_BYTES));
                chk("rayV", rayV, exp_dir(bv, dx, dy, k % w, k / w));
                chk("rayQ", rayQ, q);
                k++;
                if (k == n) last_g = t;
            end
            if (done_at < 0 && last_g >= 0 && t >= last_g + 2 && busy_v == '0) done_at = t + 2;
            chk("frameDone", frameDone, done_at >= 0 && t == done_at);
            chk("frameBusy", frameBusy, done_at < 0 || t <= done_at);
            prev_g = unitStart;
            @(posedge clock);
            tick_units(exp_g, dmin, dmax, t == abort_at);
            if (t == abort_at) return;
            if (done_at >= 0 && t == done_at + 1) begin
                chk("flush_pulses", flushes, (flush && n > 0) ? 1 : 0);
                if (hold_len > 0) chk("hold_grants", holds, 0);
                $display("frame %0dx%0d complete, %0d grants, done at cycle %0d", w, h, glog.size(), done_at);
                return;
            end
        end
        vectors++;
        miscompares++;
        $error("FAIL frame_timeout observed=%0d granted expected=%0d", k, n);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_frameBusy"}, frameBusy, 0);
        chk({tag, "_frameDone"}, frameDone, 0);
        chk({tag, "_unitStart"}, unitStart, 0);
        chk({tag, "_unitFlush"}, unitFlush, 0);
        chk({tag, "_rayQ"}, rayQ, 0);
        chk({tag, "_rayV"}, rayV, 0);
        chk({tag, "_pixelAddress"}, pixelAddress, 0);
    endtask

    initial begin
        vec3_t q, bv, dx, dy;
        int    w, h;
        bit    fl;
        logic [31:0] base;
        for (int i = 0; i < NU; i++) busy_cnt[i] = 0;
        reset = 1'b1; frameStart = 1'b0; frameFlush = 1'b0;
        frameWidth = '0; frameHeight = '0; frameAddress = '0;
        cameraQ = '0; baseV = '0; deltaX = '0; deltaY = '0; unitBusy = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check_all_zero("reset");
        $display("reset state checked");

        // 2x2 frame with units 2,3 held busy: grants alternate u0,u1.
        q  = {16'h0003, 16'h0002, 16'h0001};
        bv = {16'd7, 16'd5, 16'd3};
        dx = {16'd1, 16'd2, 16'd3};
        dy = {16'd10, 16'd20, 16'd30};
        run_frame(2, 2, 1'b0, 32'h0000_1000, q, bv, dx, dy, 1, 1, 4'b1100, 0, 0, -1);
        chk("seq_len", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk($sformatf("seq%0d", i), glog[i], i % 2);

        // Direction stepping 3x2.
        run_frame(3, 2, 1'b0, 32'h0000_2000, q, {16'd100, 16'd0, 16'd0},
                  {16'd0, 16'd0, 16'd1}, {16'd0, 16'd1, 16'd0}, 0, 2, '0, 0, 0, -1);

        // Flush before dispatch.
        run_frame(3, 3, 1'b1, 32'h0000_3000, q, bv, dx, dy, 0, 3, '0, 0, 0, -1);

        // All units busy for 10 cycles.
        run_frame(4, 4, 1'b0, 32'h0000_4000, q, bv, dx, dy, 0, 3, '0, 1, 10, -1);

        // Busy tied low: lag rule alone keeps a unit from back-to-back grants.
        run_frame(5, 4, 1'b0, 32'h0000_5000, q, bv, dx, dy, 0, 0, '0, 0, 0, -1);

        // Empty frame.
        run_frame(0, 5, 1'b0, 32'h0000_6000, q, bv, dx, dy, 0, 0, '0, 0, 0, -1);
        chk("empty_grants", glog.size(), 0);

        // Reset in the middle of dispatch, then rerun from pixel (0,0).
        run_frame(4, 4, 1'b0, 32'h0000_7000, q, bv, dx, dy, 1, 2, '0, 0, 0, 5);
        @(negedge clock);
        reset = 1'b0;
        unitBusy = busy_now();
        #1;
        check_all_zero("after_reset");
        @(posedge clock);
        tick_units('0, 0, 0, 1'b0);
        run_frame(4, 4, 1'b0, 32'h0000_7000, q, bv, dx, dy, 1, 2, '0, 0, 0, -1);

        // Randomized frames.
        for (int r = 0; r < 6; r++) begin
            w    = int'($urandom_range(6, 1));
            h    = int'($urandom_range(6, 1));
            fl   = 1'($urandom_range(1, 0));
            base = $urandom();
            q    = vec3_t'({$urandom(), $urandom()});
            bv   = vec3_t'({$urandom(), $urandom()});
            dx   = vec3_t'({$urandom(), $urandom()});
            dy   = vec3_t'({$urandom(), $urandom()});
            run_frame(w, h, fl, base, q, bv, dx, dy, 0, 5, '0, 0, 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
